// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with valid/ready handshakes on both sides.
// A new word can be accepted in the same cycle the previous word's last bit leaves.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             last_bit;
  logic             load;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && s_ready && last_bit));
  assign load     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if ((state_q == SHIFT) && s_ready) begin
      if (!last_bit) begin
        // Move the next bit toward the output end; vacated bits fill with zero.
        sreg_d = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
      end else begin
        state_d = IDLE;
      end
    end
    if (load) begin
      sreg_d  = p_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign s_valid = busy;
  assign s_out   = busy && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign s_first = busy && (cnt_q == '0);
  assign s_last  = busy && last_bit;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 4: parallel word width in bits; legal range WIDTH >= 2.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = shift out bit 0 first, 0 = shift out bit WIDTH-1 first.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: p_in holds a word offered for serialization.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts p_in in this cycle.
REQ-007 The block SHALL have port p_in, input, WIDTH bits: parallel word to serialize.
REQ-008 The block SHALL have port s_out, output, 1 bit: current serial bit.
REQ-009 The block SHALL have port s_valid, output, 1 bit: s_out carries a valid bit.
REQ-010 The block SHALL have port s_ready, input, 1 bit: the serial sink accepts s_out in this cycle.
REQ-011 The block SHALL have port s_first, output, 1 bit: s_out is bit 0 of the current word's shift order.
REQ-012 The block SHALL have port s_last, output, 1 bit: s_out is the final bit of the current word.
REQ-013 The block SHALL have port busy, output, 1 bit: a word is in flight (state SHIFT).

Function
REQ-014 The block SHALL hold a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and a two-state FSM: IDLE and SHIFT.
REQ-015 The block SHALL drive in_ready = (IDLE) OR (SHIFT AND s_ready AND counter == WIDTH-1), forced 0 while rst is high.
REQ-016 The block SHALL load the word on in_valid AND in_ready: shift register <= p_in, counter <= 0, state <= SHIFT.
REQ-017 The block SHALL present the first bit of an accepted word in the cycle after acceptance; latency is 1 cycle.
REQ-018 In SHIFT, the block SHALL drive s_valid = 1, s_first = (counter == 0), s_last = (counter == WIDTH-1), and busy = 1.
REQ-019 In SHIFT, the block SHALL drive s_out = shift register bit 0 when LSB_FIRST = 1, otherwise bit WIDTH-1.
REQ-020 In IDLE, the block SHALL drive s_valid, s_out, s_first, s_last and busy to 0.
REQ-021 On s_valid AND s_ready with counter < WIDTH-1, the block SHALL shift the register one place toward the output end, zero-fill, and increment the counter.
REQ-022 On s_valid AND s_ready with counter == WIDTH-1, the block SHALL load p_in if in_valid = 1 (back-to-back, no idle cycle); otherwise it SHALL go to IDLE.
REQ-023 When s_valid = 1 and s_ready = 0, the block SHALL hold s_out, s_first, s_last, the counter and the register unchanged; in_ready = 0.
REQ-024 Changes on p_in after acceptance SHALL NOT affect the word in flight.
REQ-025 in_valid while busy and not on the last accepted bit SHALL be ignored (in_ready = 0); the source holds the word.
REQ-026 The block SHALL never drop or repeat a bit; exactly WIDTH s_valid&&s_ready handshakes SHALL occur per accepted word.

Reset
REQ-027 With rst high at a clock edge, the block SHALL set state IDLE, counter 0, shift register 0; all outputs read 0 in the following cycle.
REQ-028 Reset SHALL take priority over any load or shift in the same cycle, and a word in flight SHALL be discarded without completion.
REQ-029 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification (WIDTH=4, LSB_FIRST=1 unless stated)
REQ-030 The bench SHALL check reset: rst high 2 cycles with in_valid=1 -> in_ready=0 and s_valid=0 throughout; in_ready=1 in the first cycle after release.
REQ-031 The bench SHALL check a single word: p_in=4'b1011, s_ready=1 -> s_out 1,1,0,1 on cycles N+1..N+4, s_first on the first, s_last on the fourth, then s_valid=0 and busy=0.
REQ-032 The bench SHALL check backpressure: same word with s_ready=0 for 3 cycles at the second bit -> s_out=1 held, s_first=0, s_last=0; the sequence then resumes 0,1.
REQ-033 The bench SHALL check back-to-back: in_valid held with 4'hA then 4'h5 -> 8 consecutive s_valid cycles, s_out 0,1,0,1,1,0,1,0, and in_ready=1 only in the cycle of the first word's s_last.
REQ-034 The bench SHALL check mid-word reset: rst at the third bit of 4'hF -> s_valid=0 in the next cycle, with no remaining bits emitted.
REQ-035 The bench SHALL check MSB-first: with LSB_FIRST=0 and p_in=4'b1000 -> s_out 1,0,0,0.
